// File: rtl/int2flt_seq.sv
`default_nettype none
// ============================================================================
// Module   : int2flt_seq
// Brief    : Sequential int16 -> IEEE-754 binary16 converter (RNE) via data_mem.
// Revision : 1.0
// ============================================================================
module int2flt_seq #(
  parameter logic [7:0] IN_LO_ADDR  = 8'd0,
  parameter logic [7:0] OUT_LO_ADDR = 8'd2,
  parameter int         BIAS        = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RD_LO = 4'd1,
    S_RD_HI = 4'd2,
    S_NORM  = 4'd3,
    S_ROUND = 4'd4,
    S_ZERO  = 4'd5,
    S_WR_LO = 4'd6,
    S_WR_HI = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  localparam logic [4:0] c_EXP_TOP = 5'(BIAS + 15);

  state_t      r_state;
  state_t      w_next;
  logic        r_start_q;
  logic [7:0]  r_lo;
  logic        r_sign;
  logic [15:0] r_mag;
  logic [3:0]  r_sc;
  logic [15:0] r_result;

  logic        w_trigger;
  logic [15:0] w_raw;
  logic [15:0] w_mag_in;
  logic [4:0]  w_exp;
  logic [9:0]  w_mant;
  logic        w_round_up;
  logic [10:0] w_mant_sum;
  logic [15:0] w_rounded;

  assign w_trigger = r_start_q & ~start;
  assign w_raw     = {mem_rdata, r_lo};
  // 0x8000 negates to itself, which is the correct unsigned magnitude.
  assign w_mag_in  = mem_rdata[7] ? (~w_raw + 16'd1) : w_raw;

  // Rounding: guard is mag[4], sticky is OR of mag[3:0]; ties go to even.
  assign w_exp      = c_EXP_TOP - 5'(r_sc);
  assign w_mant     = r_mag[14:5];
  assign w_round_up = r_mag[4] & ((|r_mag[3:0]) | w_mant[0]);
  assign w_mant_sum = {1'b0, w_mant} + 11'(w_round_up);
  assign w_rounded  = w_mant_sum[10] ? {r_sign, w_exp + 5'd1, 10'd0}
                                     : {r_sign, w_exp, w_mant_sum[9:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_start_q <= start;
    end
  end

  always_comb begin
    w_next    = r_state;
    done      = 1'b0;
    mem_addr  = 8'd0;
    mem_wdata = 8'd0;
    mem_we    = 1'b0;
    case (r_state)
      S_IDLE:  if (w_trigger) w_next = S_RD_LO;
      S_RD_LO: begin
        mem_addr = IN_LO_ADDR;
        w_next   = S_RD_HI;
      end
      S_RD_HI: begin
        mem_addr = IN_LO_ADDR + 8'd1;
        w_next   = (w_mag_in == 16'd0) ? S_ZERO : S_NORM;
      end
      S_NORM:  if (r_mag[15]) w_next = S_ROUND;
      S_ROUND: w_next = S_WR_LO;
      S_ZERO:  w_next = S_WR_LO;
      S_WR_LO: begin
        mem_addr  = OUT_LO_ADDR;
        mem_wdata = r_result[7:0];
        mem_we    = 1'b1;
        w_next    = S_WR_HI;
      end
      S_WR_HI: begin
        mem_addr  = OUT_LO_ADDR + 8'd1;
        mem_wdata = r_result[15:8];
        mem_we    = 1'b1;
        w_next    = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lo     <= 8'd0;
      r_sign   <= 1'b0;
      r_mag    <= 16'd0;
      r_sc     <= 4'd0;
      r_result <= 16'd0;
    end else begin
      case (r_state)
        S_RD_LO: r_lo <= mem_rdata;
        S_RD_HI: begin
          r_sign <= mem_rdata[7];
          r_mag  <= w_mag_in;
          r_sc   <= 4'd0;
        end
        S_NORM: begin
          if (!r_mag[15]) begin
            r_mag <= {r_mag[14:0], 1'b0};
            r_sc  <= r_sc + 4'd1;
          end
        end
        S_ROUND: r_result <= w_rounded;
        S_ZERO:  r_result <= 16'h0000;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_int2flt_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_int2flt_seq
// Brief    : Self-checking bench for int2flt_seq against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_int2flt_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;

  logic [7:0] in_lo;
  logic [7:0] in_hi;
  logic [7:0] out_lo = 8'h00;
  logic [7:0] out_hi = 8'h00;
  int         stray_wr = 0;

  int tests = 0;
  int fails = 0;

  int2flt_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (mem_addr)
      8'd0:    mem_rdata = in_lo;
      8'd1:    mem_rdata = in_hi;
      8'd2:    mem_rdata = out_lo;
      8'd3:    mem_rdata = out_hi;
      default: mem_rdata = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_addr == 8'd2)      out_lo <= mem_wdata;
      else if (mem_addr == 8'd3) out_hi <= mem_wdata;
      else                       stray_wr <= stray_wr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value-level model: magnitude, exponent = floor(log2), RNE on the remainder.
  function automatic logic [15:0] ref_half(input logic [15:0] x, output int lat);
    int v, m, e, r, q, rem, half;
    logic s;
    v = int'($signed(x));
    s = (v < 0);
    m = s ? -v : v;
    if (m == 0) begin
      lat = 6;
      return 16'h0000;
    end
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    lat = 7 + (15 - e);
    if (e <= 10) begin
      q = m << (10 - e);
    end else begin
      r    = e - 10;
      q    = m >> r;
      rem  = m - (q << r);
      half = 1 << (r - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == 2048) begin
        q = 1024;
        e++;
      end
    end
    return {s, 5'(e + 15), 10'(q - 1024)};
  endfunction

  task automatic run_conv(input logic [15:0] x, input bit restart_mid);
    int lat_exp, lat, dones, wes, stray0;
    logic [15:0] exp_r;
    bit seen;
    exp_r  = ref_half(x, lat_exp);
    in_lo  = x[7:0];
    in_hi  = x[15:8];
    stray0 = stray_wr;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    lat = 0; dones = 0; wes = 0; seen = 1'b0;
    for (int c = 1; c <= lat_exp + 4; c++) begin
      @(negedge clk);
      if (restart_mid && c == 5) start = 1'b1;
      if (restart_mid && c == 7) start = 1'b0;
      if (mem_we) wes++;
      if (done) begin
        dones++;
        if (!seen) begin
          lat  = c;
          seen = 1'b1;
        end
      end
    end
    check($sformatf("latency[%04h]", x), lat, lat_exp);
    check($sformatf("done_pulses[%04h]", x), dones, 1);
    check($sformatf("we_cycles[%04h]", x), wes, 2);
    check($sformatf("result[%04h]", x), {16'h0, out_hi, out_lo}, {16'h0, exp_r});
    check($sformatf("stray_writes[%04h]", x), stray_wr - stray0, 0);
  endtask

  initial begin
    logic [15:0] rv;
    reset = 1'b0;
    start = 1'b0;
    in_lo = 8'h00;
    in_hi = 8'h00;
    @(negedge clk);
    check("rst_done", done, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_conv(16'h0001, 1'b0);
    check("vec_0001", {out_hi, out_lo}, 16'h3C00);
    run_conv(16'h0000, 1'b0);
    run_conv(16'hFFFF, 1'b0);
    check("vec_FFFF", {out_hi, out_lo}, 16'hBC00);
    run_conv(16'h8000, 1'b0);
    check("vec_8000", {out_hi, out_lo}, 16'hF800);
    run_conv(16'h7FFF, 1'b0);
    check("vec_7FFF", {out_hi, out_lo}, 16'h7800);
    run_conv(16'h0801, 1'b0);
    check("vec_0801", {out_hi, out_lo}, 16'h6800);
    run_conv(16'h0803, 1'b0);
    check("vec_0803", {out_hi, out_lo}, 16'h6802);
    run_conv(16'h0805, 1'b0);
    check("vec_0805", {out_hi, out_lo}, 16'h6802);

    run_conv(16'h0001, 1'b1);

    // Abort a conversion mid-normalisation with an asynchronous reset.
    in_lo = 8'h01;
    in_hi = 8'h00;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_done", done, 0);
    check("async_we", mem_we, 0);
    check("async_addr", mem_addr, 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    run_conv(16'hFC00, 1'b0);
    check("vec_FC00", {out_hi, out_lo}, 16'hE400);

    run_conv(16'h0064, 1'b0);
    check("vec_0064", {out_hi, out_lo}, 16'h5640);
    run_conv(16'hFF9C, 1'b0);
    check("vec_FF9C", {out_hi, out_lo}, 16'hD640);

    for (int i = 0; i < 24; i++) begin
      rv = 16'($urandom_range(0, 65535));
      run_conv(rv, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
